// File: rtl/gcd_param_if.sv
// gcd_param_if: go/done handshake bundle between a GCD client and the gcd_param engine
//   go, in1, in2           : request and operands, driven by the master
//   out, done, busy,
//   zero_err, cycles       : result and status, driven by the engine (slave)
interface gcd_param_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             go;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] out;
  logic             done;
  logic             busy;
  logic             zero_err;
  logic [CNT_W-1:0] cycles;
  modport master (output go, in1, in2, input out, done, busy, zero_err, cycles);
  modport slave  (input go, in1, in2, output out, done, busy, zero_err, cycles);
endinterface

// File: rtl/gcd_param.sv
// gcd_param: multi-cycle gcd(in1, in2) engine, subtractive (MODE 0) or binary Stein (MODE 1)
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of gcd_param_if (go/in1/in2 in; out/done/busy/zero_err/cycles out)
module gcd_param #(
  parameter int WIDTH = 32,
  parameter int MODE  = 0,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  gcd_param_if.slave  bus
);
  localparam int KW = $clog2(WIDTH) + 1;
  typedef enum logic {IDLE, CALC} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_out;
  logic [KW-1:0]    r_k;
  logic [CNT_W-1:0] r_cyc;
  logic             r_done;
  logic             r_zerr;
  logic             w_eq;
  logic             w_agt;
  logic             w_zero_in;
  logic             w_sat;
  logic [WIDTH-1:0] w_amb;
  logic [WIDTH-1:0] w_bma;
  assign w_eq      = r_a == r_b;
  assign w_agt     = r_a > r_b;
  assign w_amb     = r_a - r_b;
  assign w_bma     = r_b - r_a;
  assign w_sat     = &r_cyc;
  assign w_zero_in = (bus.in1 == '0) || (bus.in2 == '0);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_k     <= '0;
      r_out   <= '0;
      r_cyc   <= '0;
      r_done  <= 1'b0;
      r_zerr  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (bus.go) begin
          r_a    <= bus.in1;
          r_b    <= bus.in2;
          r_k    <= '0;
          r_cyc  <= '0;
          r_zerr <= 1'b0;
          // a zero operand short-circuits: gcd(x,0) = x, answered on the accepting edge
          if (w_zero_in) begin
            r_out  <= bus.in1 | bus.in2;
            r_done <= 1'b1;
            r_zerr <= (bus.in1 | bus.in2) == '0;
          end else
            r_state <= CALC;
        end
      end else begin
        r_cyc <= w_sat ? r_cyc : r_cyc + 1'b1;
        if (w_eq) begin
          // k counts common factors of two stripped by Stein; always 0 in MODE 0
          r_out   <= r_a << r_k;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end else if (MODE == 0) begin
          if (w_agt) r_a <= w_amb;
          else       r_b <= w_bma;
        end else if (!r_a[0] && !r_b[0]) begin
          r_a <= r_a >> 1;
          r_b <= r_b >> 1;
          r_k <= r_k + 1'b1;
        end else if (!r_a[0])
          r_a <= r_a >> 1;
        else if (!r_b[0])
          r_b <= r_b >> 1;
        else if (w_agt)
          r_a <= w_amb >> 1;
        else
          r_b <= w_bma >> 1;
      end
    end
  assign bus.out      = r_out;
  assign bus.done     = r_done;
  assign bus.busy     = r_state == CALC;
  assign bus.zero_err = r_zerr;
  assign bus.cycles   = r_cyc;
endmodule

// File: tb/tb_gcd_param.sv
// tb_gcd_param: directed self-checking bench for gcd_param across modes, widths and counter sizes
module tb_gcd_param;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  gcd_param_if #(.WIDTH(32), .CNT_W(16)) i0();
  gcd_param_if #(.WIDTH(32), .CNT_W(16)) i1();
  gcd_param_if #(.WIDTH(8),  .CNT_W(16)) i2();
  gcd_param_if #(.WIDTH(8),  .CNT_W(16)) i3();
  gcd_param_if #(.WIDTH(32), .CNT_W(4))  i4();
  gcd_param #(.WIDTH(32), .MODE(0), .CNT_W(16)) u0 (.clk(clk), .rst(rst), .bus(i0));
  gcd_param #(.WIDTH(32), .MODE(1), .CNT_W(16)) u1 (.clk(clk), .rst(rst), .bus(i1));
  gcd_param #(.WIDTH(8),  .MODE(0), .CNT_W(16)) u2 (.clk(clk), .rst(rst), .bus(i2));
  gcd_param #(.WIDTH(8),  .MODE(1), .CNT_W(16)) u3 (.clk(clk), .rst(rst), .bus(i3));
  gcd_param #(.WIDTH(32), .MODE(0), .CNT_W(4))  u4 (.clk(clk), .rst(rst), .bus(i4));

  task automatic set_in(input int u, input logic g, input logic [31:0] a, input logic [31:0] b);
    case (u)
      0: begin i0.go = g; i0.in1 = a; i0.in2 = b; end
      1: begin i1.go = g; i1.in1 = a; i1.in2 = b; end
      2: begin i2.go = g; i2.in1 = a[7:0]; i2.in2 = b[7:0]; end
      3: begin i3.go = g; i3.in1 = a[7:0]; i3.in2 = b[7:0]; end
      default: begin i4.go = g; i4.in1 = a; i4.in2 = b; end
    endcase
  endtask

  function automatic logic [31:0] get_out(input int u);
    case (u)
      0: return i0.out;
      1: return i1.out;
      2: return 32'(i2.out);
      3: return 32'(i3.out);
      default: return i4.out;
    endcase
  endfunction

  function automatic logic [31:0] get_cyc(input int u);
    case (u)
      0: return 32'(i0.cycles);
      1: return 32'(i1.cycles);
      2: return 32'(i2.cycles);
      3: return 32'(i3.cycles);
      default: return 32'(i4.cycles);
    endcase
  endfunction

  function automatic logic get_done(input int u);
    case (u)
      0: return i0.done;
      1: return i1.done;
      2: return i2.done;
      3: return i3.done;
      default: return i4.done;
    endcase
  endfunction

  function automatic logic get_busy(input int u);
    case (u)
      0: return i0.busy;
      1: return i1.busy;
      2: return i2.busy;
      3: return i3.busy;
      default: return i4.busy;
    endcase
  endfunction

  function automatic logic get_zerr(input int u);
    case (u)
      0: return i0.zero_err;
      1: return i1.zero_err;
      2: return i2.zero_err;
      3: return i3.zero_err;
      default: return i4.zero_err;
    endcase
  endfunction

  // issue one go, then sample each negedge until done; lat = negedges after the accepting edge
  task automatic run_op(input int u, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int cyc, output logic zerr,
                        output int busy_n, output int lat);
    bit seen = 0;
    busy_n = 0;
    lat = 0;
    @(negedge clk);
    set_in(u, 1'b1, a, b);
    @(posedge clk);
    while (!seen && lat < 3000) begin
      @(negedge clk);
      if (lat == 0) set_in(u, 1'b0, a, b);
      lat++;
      if (get_done(u)) seen = 1;
      else if (get_busy(u)) busy_n++;
    end
    res = get_out(u);
    cyc = int'(get_cyc(u));
    zerr = get_zerr(u);
    checks++;
    if (!seen) begin failures++; $display("FAIL timeout u%0d (%0d,%0d): no done after %0d cycles", u, a, b, lat); end
  endtask

  task automatic test_reset();
    logic [31:0] dummy;
    dummy = 32'd0;
    for (int u = 0; u < 5; u++) set_in(u, 1'b0, dummy, dummy);
    #2;
    for (int u = 0; u < 5; u++) begin
      checks++;
      if ({get_out(u), get_done(u), get_busy(u), get_zerr(u), get_cyc(u)} !== 67'd0) begin
        failures++;
        $display("FAIL reset_state u%0d: out=%0d done=%0b busy=%0b zerr=%0b cyc=%0d, all must be 0", u, get_out(u), get_done(u), get_busy(u), get_zerr(u), get_cyc(u));
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_subtractive();
    logic [31:0] r; int c, bn, l; logic z;
    run_op(0, 32'd12, 32'd8, r, c, z, bn, l);
    checks++; if (r !== 32'd4) begin failures++; $display("FAIL sub_12_8_out: got %0d expected 4", r); end
    checks++; if (c != 3) begin failures++; $display("FAIL sub_12_8_cycles: got %0d expected 3", c); end
    checks++; if (bn != 3) begin failures++; $display("FAIL sub_12_8_busy_cycles: got %0d expected 3", bn); end
    checks++; if (l != 4) begin failures++; $display("FAIL sub_12_8_latency: got %0d expected 4", l); end
    @(negedge clk);
    checks++; if (get_done(0) !== 1'b0) begin failures++; $display("FAIL done_pulse_width: done=%0b expected 0", get_done(0)); end
    run_op(0, 32'd1071, 32'd462, r, c, z, bn, l);
    checks++; if (r !== 32'd21) begin failures++; $display("FAIL sub_1071_462: got %0d expected 21", r); end
  endtask

  task automatic test_binary();
    logic [31:0] r; int c, bn, l; logic z;
    run_op(1, 32'd12, 32'd8, r, c, z, bn, l);
    checks++; if (r !== 32'd4) begin failures++; $display("FAIL bin_12_8_out: got %0d expected 4", r); end
    checks++; if (c != 5) begin failures++; $display("FAIL bin_12_8_cycles: got %0d expected 5", c); end
    run_op(1, 32'd7, 32'd7, r, c, z, bn, l);
    checks++; if (r !== 32'd7) begin failures++; $display("FAIL bin_7_7_out: got %0d expected 7", r); end
    checks++; if (c != 1) begin failures++; $display("FAIL bin_7_7_cycles: got %0d expected 1", c); end
  endtask

  task automatic test_vectors();
    int          vu [10] = '{0, 0, 1, 1, 1, 2, 2, 3, 3, 3};
    logic [31:0] va [10] = '{1071, 48, 1071, 17, 100, 255, 200, 13, 128, 64};
    logic [31:0] vb [10] = '{462, 18, 462, 5, 75, 85, 120, 169, 96, 48};
    logic [31:0] ve [10] = '{21, 6, 21, 1, 25, 85, 40, 13, 32, 16};
    logic [31:0] r; int c, bn, l; logic z;
    for (int i = 0; i < 10; i++) begin
      run_op(vu[i], va[i], vb[i], r, c, z, bn, l);
      checks++;
      if (r !== ve[i] || z !== 1'b0) begin
        failures++;
        $display("FAIL vector%0d u%0d (%0d,%0d): out=%0d zerr=%0b expected out=%0d zerr=0", i, vu[i], va[i], vb[i], r, z, ve[i]);
      end
    end
  endtask

  task automatic test_zero();
    logic [31:0] r; int c, bn, l; logic z;
    run_op(0, 32'd0, 32'd15, r, c, z, bn, l);
    checks++; if (r !== 32'd15 || z !== 1'b0) begin failures++; $display("FAIL zero_0_15: out=%0d zerr=%0b expected 15/0", r, z); end
    checks++; if (l != 1 || c != 0 || bn != 0) begin failures++; $display("FAIL zero_0_15_timing: lat=%0d cyc=%0d busy=%0d expected 1/0/0", l, c, bn); end
    run_op(0, 32'd0, 32'd0, r, c, z, bn, l);
    checks++; if (r !== 32'd0 || z !== 1'b1) begin failures++; $display("FAIL zero_0_0: out=%0d zerr=%0b expected 0/1", r, z); end
    run_op(3, 32'd40, 32'd0, r, c, z, bn, l);
    checks++; if (r !== 32'd40 || z !== 1'b0 || l != 1) begin failures++; $display("FAIL zero_bin_40_0: out=%0d zerr=%0b lat=%0d expected 40/0/1", r, z, l); end
    run_op(0, 32'd12, 32'd8, r, c, z, bn, l);
    checks++; if (z !== 1'b0 || r !== 32'd4) begin failures++; $display("FAIL zero_err_clear: out=%0d zerr=%0b expected 4/0", r, z); end
  endtask

  task automatic test_handshake();
    int n = 0;
    @(negedge clk);
    set_in(0, 1'b1, 32'd12, 32'd8);
    @(negedge clk);
    set_in(0, 1'b1, 32'd9, 32'd6);
    @(negedge clk);
    set_in(0, 1'b0, 32'd9, 32'd6);
    while (!get_done(0) && n < 100) begin @(negedge clk); n++; end
    checks++; if (get_out(0) !== 32'd4 || get_cyc(0) !== 32'd3) begin failures++; $display("FAIL go_while_busy: out=%0d cyc=%0d expected 4/3", get_out(0), get_cyc(0)); end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    @(negedge clk);
    set_in(0, 1'b1, 32'd12, 32'd8);
    @(negedge clk);
    set_in(0, 1'b1, 32'd35, 32'd14);
    while (!get_done(0) && n < 100) begin @(negedge clk); n++; end
    checks++; if (get_out(0) !== 32'd4) begin failures++; $display("FAIL b2b_first: out=%0d expected 4", get_out(0)); end
    @(negedge clk);
    set_in(0, 1'b0, 32'd35, 32'd14);
    checks++; if (get_done(0) !== 1'b0 || get_busy(0) !== 1'b1) begin failures++; $display("FAIL b2b_accept: done=%0b busy=%0b expected 0/1", get_done(0), get_busy(0)); end
    n = 0;
    while (!get_done(0) && n < 100) begin @(negedge clk); n++; end
    checks++; if (get_out(0) !== 32'd7) begin failures++; $display("FAIL b2b_second: out=%0d expected 7", get_out(0)); end
  endtask

  task automatic test_saturation();
    logic [31:0] r; int c, bn, l; logic z;
    run_op(4, 32'd20, 32'd1, r, c, z, bn, l);
    checks++; if (r !== 32'd1) begin failures++; $display("FAIL sat_out: got %0d expected 1", r); end
    checks++; if (c != 15) begin failures++; $display("FAIL sat_cycles: got %0d expected 15", c); end
    checks++; if (bn != 20) begin failures++; $display("FAIL sat_busy_cycles: got %0d expected 20", bn); end
  endtask

  task automatic test_async_reset();
    int late = 0;
    @(negedge clk);
    set_in(0, 1'b1, 32'd12, 32'd8);
    @(negedge clk);
    set_in(0, 1'b0, 32'd12, 32'd8);
    checks++; if (get_busy(0) !== 1'b1) begin failures++; $display("FAIL areset_pre_busy: busy=%0b expected 1", get_busy(0)); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (get_out(0) !== 32'd0 || get_done(0) !== 1'b0 || get_busy(0) !== 1'b0 || get_cyc(0) !== 32'd0) begin
      failures++;
      $display("FAIL areset_immediate: out=%0d done=%0b busy=%0b cyc=%0d expected all 0", get_out(0), get_done(0), get_busy(0), get_cyc(0));
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (8) begin @(negedge clk); if (get_done(0)) late++; end
    checks++; if (late != 0) begin failures++; $display("FAIL areset_no_done: done seen %0d times expected 0", late); end
  endtask

  initial begin
    test_reset();
    test_subtractive();
    test_binary();
    test_vectors();
    test_zero();
    test_handshake();
    test_back_to_back();
    test_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
